// File: rtl/tm1637_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tm1637_pkg
// Brief    : Shared constants, FSM encoding and hex-to-segment table for the
//            TM1637 display refresh controller.
// Revision : 1.0  initial release
// ============================================================================
package tm1637_pkg;

  localparam logic [7:0] CMD_DATA_AUTOINC = 8'h40;
  localparam logic [7:0] CMD_ADDR0        = 8'hC0;
  localparam logic [7:0] CMD_DISPCTRL     = 8'h80;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] ACK    = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam logic [2:0] LAST_BYTE_IDX = 3'd6;

  // Entry n is the segment pattern for hex digit n (bit0=a .. bit6=g, DP=0).
  localparam logic [15:0][7:0] HEX_SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef struct packed {
    logic [31:0] digits;
    logic [2:0]  brightness;
    logic        display_on;
  } snapshot_t;

  function automatic logic is_frame_end(input logic [2:0] idx);
    return (idx == 3'd0) || (idx == 3'd5) || (idx == LAST_BYTE_IDX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tm1637_display_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tm1637_display_ctrl_if
// Brief    : Write-port bundle between the refresh controller and spi_master.
// Revision : 1.0  initial release
// ============================================================================
interface tm1637_display_ctrl_if;
  logic [7:0] spi_data;
  logic       spi_wr;
  logic       spi_buffempty;
  logic       spi_ss;
  logic [2:0] spi_prescaller;
  logic       spi_lsbfirst;
  logic [1:0] spi_mode;

  modport master (
    output spi_data, spi_wr, spi_prescaller, spi_lsbfirst, spi_mode,
    input  spi_buffempty, spi_ss
  );

  modport slave (
    input  spi_data, spi_wr, spi_prescaller, spi_lsbfirst, spi_mode,
    output spi_buffempty, spi_ss
  );
endinterface
`default_nettype wire

// File: rtl/tm1637_seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : tm1637_seg_decode
// Brief    : Combinational hex nibble to TM1637 7-segment byte (DP off).
// Revision : 1.0  initial release
// ============================================================================
module tm1637_seg_decode
  import tm1637_pkg::*;
(
  input  wire logic [3:0] nibble,
  output logic      [7:0] seg
);
  assign seg = HEX_SEG_TABLE[nibble];
endmodule
`default_nettype wire

// File: rtl/tm1637_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tm1637_display_ctrl
// Brief    : Sequences the 3-frame TM1637 refresh through spi_master, on a
//            start pulse or a periodic tick. Macro TM1637_HEX_DECODE_EN
//            selects hex-nibble decoding of digits[15:0].
// Revision : 1.0  initial release
// ============================================================================
module tm1637_display_ctrl
  import tm1637_pkg::*;
#(
  parameter logic [2:0]  PRESCALER      = 3'd4,
  parameter logic [31:0] REFRESH_CYCLES = 32'd0,
  parameter logic [15:0] FRAME_GAP      = 16'd8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  input  wire logic [31:0] digits,
  input  wire logic [2:0]  brightness,
  input  wire logic        display_on,
  output logic             busy,
  output logic             done,
  output logic             err,
  tm1637_display_ctrl_if.master spi
);

  logic [2:0]      r_state;
  logic [2:0]      r_idx;
  logic [31:0]     r_wait_cnt;
  logic [31:0]     r_refresh_cnt;
  logic            r_pending;
  snapshot_t       r_snap;
  logic [7:0]      r_spi_data;
  logic            r_spi_wr;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_tick;
  logic            w_trigger;
  logic            w_timeout;
  logic            w_gap_over;
  logic [3:0][7:0] w_seg;
  logic [7:0]      w_byte;

  assign spi.spi_data       = r_spi_data;
  assign spi.spi_wr         = r_spi_wr;
  assign spi.spi_prescaller = PRESCALER;
  assign spi.spi_lsbfirst   = 1'b1;
  assign spi.spi_mode       = 2'b11;
  assign busy               = r_busy;
  assign done               = r_done;
  assign err                = r_err;

  // Free-running period counter; held at zero when auto-refresh is disabled.
  assign w_tick = (REFRESH_CYCLES != 32'd0) &&
                  (r_refresh_cnt == REFRESH_CYCLES - 32'd1);

  always_ff @(posedge clk) begin
    if (rst || (REFRESH_CYCLES == 32'd0) || w_tick) begin
      r_refresh_cnt <= 32'd0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 32'd1;
    end
  end

`ifdef TM1637_HEX_DECODE_EN
  for (genvar i = 0; i < 4; i++) begin : g_hex_decode
    tm1637_seg_decode u_seg_decode (
      .nibble (r_snap.digits[4*i +: 4]),
      .seg    (w_seg[i])
    );
  end
  logic w_unused_hi;
  assign w_unused_hi = ^r_snap.digits[31:16];
`else
  for (genvar i = 0; i < 4; i++) begin : g_raw_seg
    assign w_seg[i] = r_snap.digits[8*i +: 8];
  end
`endif

  always_comb begin
    w_byte = CMD_DATA_AUTOINC;
    case (r_idx)
      3'd0:    w_byte = CMD_DATA_AUTOINC;
      3'd1:    w_byte = CMD_ADDR0;
      3'd2:    w_byte = w_seg[0];
      3'd3:    w_byte = w_seg[1];
      3'd4:    w_byte = w_seg[2];
      3'd5:    w_byte = w_seg[3];
      default: w_byte = CMD_DISPCTRL | {4'b0000, r_snap.display_on, r_snap.brightness};
    endcase
  end

  assign w_trigger  = start || w_tick || r_pending;
  assign w_timeout  = (r_wait_cnt + 32'd1) >= TIMEOUT_CYCLES;
  assign w_gap_over = (r_wait_cnt + 32'd1) >= {16'd0, FRAME_GAP};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= 3'd0;
      r_wait_cnt <= 32'd0;
      r_pending  <= 1'b0;
      r_snap     <= '0;
      r_spi_data <= 8'h00;
      r_spi_wr   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wait_cnt <= r_wait_cnt + 32'd1;
      if ((r_state != IDLE) && w_tick) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_wait_cnt <= 32'd0;
          if (w_trigger) begin
            r_snap    <= '{digits: digits, brightness: brightness, display_on: display_on};
            r_idx     <= 3'd0;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          if (spi.spi_buffempty) begin
            r_spi_data <= w_byte;
            r_wait_cnt <= 32'd0;
            r_state    <= STROBE;
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_spi_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        STROBE: begin
          r_spi_wr   <= 1'b1;
          r_wait_cnt <= 32'd0;
          r_state    <= ACK;
        end
        ACK: begin
          // buffempty dropping means spi_master has taken the byte.
          if (!spi.spi_buffempty) begin
            r_spi_wr   <= 1'b0;
            r_wait_cnt <= 32'd0;
            if (is_frame_end(r_idx)) begin
              r_state <= DRAIN;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= LOAD;
            end
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_spi_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        DRAIN: begin
          if (spi.spi_buffempty && spi.spi_ss) begin
            r_wait_cnt <= 32'd0;
            r_state    <= GAP;
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_spi_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        GAP: begin
          if (w_gap_over) begin
            r_wait_cnt <= 32'd0;
            if (r_idx < LAST_BYTE_IDX) begin
              r_idx   <= r_idx + 3'd1;
              r_state <= LOAD;
            end else begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_wait_cnt <= 32'd0;
          r_state    <= IDLE;
        end
        default: begin
          r_spi_wr <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tm1637_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tm1637_display_ctrl
// Brief    : Self-checking bench with a behavioural spi_master write-port model
//            driving two controller instances (manual and auto-refresh).
// Revision : 1.0  initial release
// ============================================================================
module tb_tm1637_display_ctrl;

  localparam int BT0  = 20;   // byte time, instance 0
  localparam int BT1  = 300;  // byte time, instance 1 (longer than 2000/7)
  localparam int HOLD = 6;    // ss stays low this long waiting for another byte

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, start0, start1, on0, on1;
  logic [31:0] digits0, digits1;
  logic [2:0]  bri0, bri1;
  logic        busy0, done0, err0, busy1, done1, err1;

  tm1637_display_ctrl_if if0();
  tm1637_display_ctrl_if if1();

  tm1637_display_ctrl #(.TIMEOUT_CYCLES(32'd50)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .digits(digits0), .brightness(bri0),
    .display_on(on0), .busy(busy0), .done(done0), .err(err0), .spi(if0)
  );

  tm1637_display_ctrl #(.REFRESH_CYCLES(32'd2000)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .digits(digits1), .brightness(bri1),
    .display_on(on1), .busy(busy1), .done(done1), .err(err1), .spi(if1)
  );

  logic [1:0] rst_v, wr_v, busy_v, done_v, err_v, be_v, ss_v, accept, m_prev;
  logic [7:0] data_v [2];
  int         m_cnt  [2];
  int         m_hold [2];

  assign rst_v  = {rst1, rst0};
  assign wr_v   = {if1.spi_wr, if0.spi_wr};
  assign busy_v = {busy1, busy0};
  assign done_v = {done1, done0};
  assign err_v  = {err1, err0};
  assign data_v[0] = if0.spi_data;
  assign data_v[1] = if1.spi_data;
  assign if0.spi_buffempty = be_v[0];
  assign if0.spi_ss        = ss_v[0];
  assign if1.spi_buffempty = be_v[1];
  assign if1.spi_ss        = ss_v[1];

  // spi_master write-port model: a wr rising edge takes the byte, holds
  // buffempty low for the byte time, and keeps ss low for HOLD cycles after.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst_v[g]) begin
        be_v[g] <= 1'b1; ss_v[g] <= 1'b1; m_prev[g] <= 1'b0;
        m_cnt[g] <= 0; m_hold[g] <= 0;
      end else begin
        m_prev[g] <= wr_v[g];
        if (wr_v[g] && !m_prev[g] && accept[g]) begin
          be_v[g] <= 1'b0; ss_v[g] <= 1'b0; m_hold[g] <= 0;
          m_cnt[g] <= (g == 0) ? BT0 : BT1;
        end else if (m_cnt[g] != 0) begin
          m_cnt[g] <= m_cnt[g] - 1;
          if (m_cnt[g] == 1) begin be_v[g] <= 1'b1; m_hold[g] <= HOLD; end
        end else if (m_hold[g] != 0) begin
          m_hold[g] <= m_hold[g] - 1;
          if (m_hold[g] == 1) ss_v[g] <= 1'b1;
        end
      end
    end
  end

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] obs0_q [$];
  logic [7:0] obs1_q [$];
  int         win0_q [$];
  logic [1:0] w_prev_wr = 2'b00;
  logic [1:0] w_prev_ss = 2'b11;
  int         win_cnt  [2] = '{0, 0};
  int         done_cnt [2] = '{0, 0};
  int         err_cnt  [2] = '{0, 0};
  int         last_wr_cyc, last_ev_cyc;

  function automatic logic [7:0] seg_of(input logic [31:0] d, input int k);
`ifdef TM1637_HEX_DECODE_EN
    logic [3:0] n;
    n = d[4*k +: 4];
    case (n)
      4'h0: return 8'h3F; 4'h1: return 8'h06; 4'h2: return 8'h5B; 4'h3: return 8'h4F;
      4'h4: return 8'h66; 4'h5: return 8'h6D; 4'h6: return 8'h7D; 4'h7: return 8'h07;
      4'h8: return 8'h7F; 4'h9: return 8'h6F; 4'hA: return 8'h77; 4'hB: return 8'h7C;
      4'hC: return 8'h39; 4'hD: return 8'h5E; 4'hE: return 8'h79; default: return 8'h71;
    endcase
`else
    return d[8*k +: 8];
`endif
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic [2:0] b, input logic on);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'hC0);
    for (int k = 0; k < 4; k++) exp_q.push_back(seg_of(d, k));
    exp_q.push_back(8'h80 | {4'b0000, on, b});
  endtask

  // Samples one instance each negedge; stops on done/err, after stop_bytes
  // writes, or when the cycle budget runs out (ended stays 0).
  task automatic watch(input int ch, input int max_cycles, input int stop_bytes,
                       input int poke_at, output bit ended);
    int  nb;
    bit  stop;
    nb = 0; ended = 1'b0; stop = 1'b0;
    for (int i = 0; i < max_cycles && !stop; i++) begin
      @(negedge clk);
      if (i == poke_at) begin bri0 = 3'd2; start0 = 1'b1; end
      if (i == poke_at + 1) start0 = 1'b0;
      if (wr_v[ch] && !w_prev_wr[ch]) begin
        if (ch == 0) obs0_q.push_back(data_v[ch]); else obs1_q.push_back(data_v[ch]);
        nb++; win_cnt[ch]++; last_wr_cyc = i;
      end
      if (ss_v[ch] && !w_prev_ss[ch]) begin
        if (ch == 0) win0_q.push_back(win_cnt[ch]);
        win_cnt[ch] = 0;
      end
      w_prev_wr[ch] = wr_v[ch];
      w_prev_ss[ch] = ss_v[ch];
      if (done_v[ch]) begin done_cnt[ch]++; last_ev_cyc = i; ended = 1'b1; end
      if (err_v[ch])  begin err_cnt[ch]++;  last_ev_cyc = i; ended = 1'b1; end
      if (ended || (stop_bytes > 0 && nb >= stop_bytes)) stop = 1'b1;
    end
  endtask

  task automatic kick0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy0, done0, err0, if0.spi_wr} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b want=0000", {busy0, done0, err0, if0.spi_wr});
    end
    total++;
    if (if0.spi_data !== 8'h00) begin
      bad++; $display("FAIL reset_data got=%02h want=00", if0.spi_data);
    end
    total++;
    if ({if0.spi_prescaller, if0.spi_lsbfirst, if0.spi_mode} !== {3'd4, 1'b1, 2'b11}) begin
      bad++; $display("FAIL spi_config got=%b want=100111",
                      {if0.spi_prescaller, if0.spi_lsbfirst, if0.spi_mode});
    end
    rst0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_refresh();
    bit ended;
    logic [7:0] o, e;
    int w;
    digits0 = 32'h3F06_5B4F; bri0 = 3'd7; on0 = 1'b1;
    push_exp(digits0, bri0, on0);
    win0_q.delete();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    total++;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b want=1", busy0); end
    watch(0, 2000, 0, -1, ended);
    total++;
    if (!ended || done_cnt[0] != 1) begin
      bad++; $display("FAIL refresh_done got=%0d want=1", done_cnt[0]);
    end
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL busy_fall got=%b want=0", busy0); end
    total++;
    if (obs0_q.size() != 7) begin
      bad++; $display("FAIL refresh_wr_count got=%0d want=7", obs0_q.size());
    end
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front();
      o = 8'hxx;
      if (obs0_q.size() != 0) o = obs0_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL refresh_byte%0d got=%02h want=%02h", k, o, e); end
    end
    for (int k = 0; k < 3; k++) begin
      w = -1;
      if (win0_q.size() != 0) w = win0_q.pop_front();
      total++;
      if (w != ((k == 1) ? 5 : 1)) begin
        bad++; $display("FAIL ss_window%0d got=%0d want=%0d", k, w, (k == 1) ? 5 : 1);
      end
    end
  endtask

  task automatic test_snapshot();
    bit ended;
    logic [7:0] o, e;
    int d0;
    digits0 = 32'h6D7D_077F; bri0 = 3'd7; on0 = 1'b1;
    push_exp(digits0, 3'd7, 1'b1);
    d0 = done_cnt[0];
    kick0();
    watch(0, 2000, 0, 8, ended);
    total++;
    if (!ended || done_cnt[0] != d0 + 1) begin
      bad++; $display("FAIL snap_done got=%0d want=%0d", done_cnt[0], d0 + 1);
    end
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front();
      o = 8'hxx;
      if (obs0_q.size() != 0) o = obs0_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL snap_byte%0d got=%02h want=%02h", k, o, e); end
    end
    watch(0, 200, 0, -1, ended);
    total++;
    if (ended || obs0_q.size() != 0) begin
      bad++; $display("FAIL snap_extra_refresh got=%0d bytes want=0", obs0_q.size());
    end
    obs0_q.delete();
    bri0 = 3'd7;
  endtask

  task automatic test_digits();
    bit ended;
    logic [7:0] o, e;
    digits0 = 32'hA5C3_1234; bri0 = 3'd0; on0 = 1'b0;
    push_exp(digits0, bri0, on0);
    kick0();
    watch(0, 2000, 0, -1, ended);
    total++;
    if (!ended) begin bad++; $display("FAIL digits_done got=0 want=1"); end
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front();
      o = 8'hxx;
      if (obs0_q.size() != 0) o = obs0_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL digits_byte%0d got=%02h want=%02h", k, o, e); end
    end
`ifdef TM1637_HEX_DECODE_EN
    total++;
    if (seg_of(digits0, 0) !== 8'h66) begin
      bad++; $display("FAIL hex_table got=%02h want=66", seg_of(digits0, 0));
    end
`endif
  endtask

  task automatic test_timeout();
    bit ended;
    int d0, e0, dt;
    accept[0] = 1'b0;
    d0 = done_cnt[0]; e0 = err_cnt[0];
    kick0();
    watch(0, 300, 0, -1, ended);
    dt = last_ev_cyc - last_wr_cyc;
    total++;
    if (!ended || err_cnt[0] != e0 + 1 || done_cnt[0] != d0) begin
      bad++; $display("FAIL timeout_err got err=%0d done=%0d want err=%0d done=%0d",
                      err_cnt[0], done_cnt[0], e0 + 1, d0);
    end
    total++;
    if (dt < 50 || dt > 51) begin bad++; $display("FAIL timeout_delay got=%0d want=50", dt); end
    total++;
    if ({if0.spi_wr, busy0} !== 2'b00) begin
      bad++; $display("FAIL timeout_idle got=%b want=00", {if0.spi_wr, busy0});
    end
    obs0_q.delete();
    accept[0] = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ended;
    logic [7:0] o, e;
    digits0 = 32'h1122_3344; bri0 = 3'd5; on0 = 1'b1;
    kick0();
    watch(0, 2000, 4, -1, ended);
    rst0 = 1'b1;
    @(negedge clk);
    total++;
    if ({busy0, if0.spi_wr} !== 2'b00) begin
      bad++; $display("FAIL midreset_idle got=%b want=00", {busy0, if0.spi_wr});
    end
    rst0 = 1'b0;
    obs0_q.delete(); exp_q.delete(); win0_q.delete();
    win_cnt[0] = 0; w_prev_wr[0] = 1'b0; w_prev_ss[0] = 1'b1;
    @(negedge clk);
    push_exp(digits0, bri0, on0);
    kick0();
    watch(0, 2000, 0, -1, ended);
    total++;
    if (!ended) begin bad++; $display("FAIL midreset_restart got=0 want=1"); end
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front();
      o = 8'hxx;
      if (obs0_q.size() != 0) o = obs0_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL midreset_byte%0d got=%02h want=%02h", k, o, e); end
    end
  endtask

  task automatic test_pending();
    bit ended;
    logic [7:0] o, e;
    digits1 = 32'h0102_0304; bri1 = 3'd3; on1 = 1'b1;
    @(negedge clk); rst1 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      push_exp(digits1, bri1, on1);
      watch(1, 6000, 0, -1, ended);
      total++;
      if (!ended || done_cnt[1] != r + 1) begin
        bad++; $display("FAIL auto_done%0d got=%0d want=%0d", r, done_cnt[1], r + 1);
      end
      total++;
      if (obs1_q.size() != 7) begin
        bad++; $display("FAIL auto_wr_count%0d got=%0d want=7", r, obs1_q.size());
      end
      for (int k = 0; k < 7; k++) begin
        e = exp_q.pop_front();
        o = 8'hxx;
        if (obs1_q.size() != 0) o = obs1_q.pop_front();
        total++;
        if (o !== e) begin bad++; $display("FAIL auto_byte%0d_%0d got=%02h want=%02h", r, k, o, e); end
      end
      obs1_q.delete();
      @(negedge clk);
      total++;
      if (busy1 !== 1'b1) begin
        bad++; $display("FAIL pending_restart%0d got=%b want=1", r, busy1);
      end
    end
    rst1 = 1'b1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    digits0 = '0; digits1 = '0; bri0 = '0; bri1 = '0; on0 = 1'b0; on1 = 1'b0;
    accept = 2'b11;
    test_reset();
    test_refresh();
    test_snapshot();
    test_digits();
    test_timeout();
    test_reset_mid();
    test_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tm1637_display_ctrl.md
Name: tm1637_display_ctrl

Overview:
Sequencer that drives spi_master to refresh a 4-digit TM1637 LED display.
- A refresh is triggered by a start pulse or by an internal periodic timer.
- Each refresh issues three frames:
  1. Data command 0x40 (auto-increment).
  2. Address 0xC0 followed by 4 segment bytes.
  3. Display control 0x80 | on<<3 | brightness.
- Sits between the application logic (digits, brightness) and the spi_master write port. spi_master is fixed to LSB-first, mode 3.

Parameters:
- PRESCALER, 3'd4, value driven on spi_prescaller (divider = 1<<PRESCALER).
- REFRESH_CYCLES, 32'd0, auto-refresh period in clk cycles; 0 disables auto-refresh.
- FRAME_GAP, 16'd8, idle clk cycles required after spi_ss returns high before the next frame starts.
- TIMEOUT_CYCLES, 32'd100000, maximum wait in any wait state before abort.

Ports:
- clk  in  1  system clock; same clock as spi_master clk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle refresh request.
- digits  in  32  segment bytes, digit0 in [7:0] … digit3 in [31:24].
- brightness  in  3  display brightness, 0..7.
- display_on  in  1  display enable bit.
- busy  out  1  high while a refresh is in progress.
- done  out  1  one-cycle pulse when a refresh completes.
- err  out  1  one-cycle pulse when a refresh is aborted on timeout.
- spi_data  out  8  connects to spi_master data_in.
- spi_wr  out  1  connects to spi_master wr (rising edge launches a byte).
- spi_buffempty  in  1  from spi_master buffempty.
- spi_ss  in  1  from spi_master ss.
- spi_prescaller  out  3  constant PRESCALER.
- spi_lsbfirst  out  1  constant 1.
- spi_mode  out  2  constant 2'b11.

Behaviour:
- Reset values: busy=0, done=0, err=0, spi_wr=0, spi_data=8'h00, state=IDLE, byte index=0, refresh counter=0.
- Snapshot: at trigger, digits, brightness and display_on are latched. Input changes during a refresh have no effect on it.
- Byte sequence by index:
  - 0: 0x40, end of frame.
  - 1: 0xC0.
  - 2..5: digit0..digit3.
  - 5 is end of frame.
  - 6: 0x80 | on<<3 | brightness, end of frame.
- State machine, one byte per pass:
  - IDLE: on trigger → LOAD; busy goes to 1 in the next cycle.
  - LOAD: wait for spi_buffempty=1; drive spi_data; spi_wr=0. Next state STROBE.
  - STROBE: spi_wr=1; spi_data is held stable. Next state ACK.
  - ACK: wait for spi_buffempty=0 (byte accepted), then spi_wr=0.
    - If the index is not an end of frame: index+1 → LOAD.
    - If the index is an end of frame: → DRAIN.
  - DRAIN: wait for spi_buffempty=1 and spi_ss=1 (frame closed by spi_master) → GAP.
  - GAP: count FRAME_GAP cycles.
    - If the index is less than 6: index+1 → LOAD.
    - Otherwise: → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- spi_data changes only in LOAD. spi_wr stays low for at least 1 cycle before every rising edge.
- Timeout: the wait counter is cleared on every state entry. If it reaches TIMEOUT_CYCLES in LOAD, ACK or DRAIN: err=1 for one cycle, spi_wr=0, busy=0 → IDLE.
- Trigger sources: start, or the auto-refresh tick (counter wraps at REFRESH_CYCLES-1; the counter free-runs).
- Trigger edge cases:
  - start and tick in the same cycle → a single refresh.
  - start while busy is ignored.
  - A tick while busy sets a pending flag. The pending refresh starts on the cycle after DONE. Only one request is pending at most.
- Reset mid-refresh: on the next clk edge the block returns to IDLE, spi_wr=0, and the pending flag is cleared. The same rst drives spi_master.
- Minimum refresh latency, trigger to done: 7 bytes × (spi byte time) + 3 × (drain + FRAME_GAP) + 2 cycles.

Optional Feature:
- TM1637_HEX_DECODE_EN defined: digits[15:0] are read as 4 hex nibbles (nibble0 = digit0). Each nibble is decoded to a TM1637 7-segment byte with DP=0. digits[31:16] are ignored.
- TM1637_HEX_DECODE_EN undefined: digits are raw segment bytes, passed through unchanged.

Decomposition:
- Package tm1637_pkg:
  - Command constants: CMD_DATA_AUTOINC=8'h40, CMD_ADDR0=8'hC0, CMD_DISPCTRL=8'h80.
  - State encoding constants: IDLE, LOAD, STROBE, ACK, DRAIN, GAP, DONE.
  - LAST_BYTE_IDX=6.
  - 16-entry hex-to-segment table.
- One sub-module: tm1637_seg_decode, combinational, nibble → segment byte. It is instantiated 4× only under TM1637_HEX_DECODE_EN.

Test Plan:
- Reset, then start with digits=32'h3F06_5B4F, brightness=3'd7, display_on=1, using the spi_master model → spi_data sequence 40, C0, 4F, 5B, 06, 3F, 8F. Exactly 7 spi_wr rising edges. Three spi_ss low windows of 1, 5 and 1 bytes. done pulses once; busy then falls.
- start pulsed again 10 cycles after a refresh begins, with brightness changed mid-refresh → second start is ignored; the last byte still reflects the snapshot (8F); exactly one done.
- REFRESH_CYCLES=2000 with a byte time longer than 2000/7 cycles → a tick during busy is deferred. The next refresh begins 1 cycle after done. There are no overlapping sequences.
- spi_buffempty held at 1 (model never accepts), TIMEOUT_CYCLES=50 → err pulses 50 cycles after STROBE. spi_wr=0, busy=0, no done.
- rst asserted for 1 cycle in the middle of the 5-byte frame → next cycle busy=0 and spi_wr=0. A following start restarts from byte 0x40.
- With TM1637_HEX_DECODE_EN, digits[15:0]=16'h1234 → segment bytes 66, 4F, 5B, 06 appear after C0, in digit0 first order.
